// File: rtl/conv_window_regfile_pkg.sv
// Shared CNN datapath constants and types, also used by the address counter.
package conv_window_regfile_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Whole storage array as one packed word, so it can be handed to the read ports.
  typedef logic [DEPTH-1:0][DATA_W-1:0] memArray_t;

endpackage

// File: rtl/conv_window_regfile_if.sv
// Bus between the address counter / pixel source and the window register file.
//
// Handshake: there is no ready. WriteEn, Clear and ReadEn are accepted at every
// rising edge where they are high. One cycle after an accepted ReadEn, exactly
// one of ReadValid or ReadErr pulses for one cycle. ReadData1..3 are updated
// only on accepted reads and hold their values otherwise. Full is a level.
interface conv_window_regfile_if
  import conv_window_regfile_pkg::*;
();

  logic   WriteEn;
  addr_t  WriteReg;
  pixel_t WriteData;
  logic   ReadEn;
  addr_t  ReadReg1;
  addr_t  ReadReg2;
  addr_t  ReadReg3;
  logic   Clear;
  pixel_t ReadData1;
  pixel_t ReadData2;
  pixel_t ReadData3;
  logic   ReadValid;
  logic   ReadErr;
  logic   Full;

  modport master (
    output WriteEn, WriteReg, WriteData, ReadEn, ReadReg1, ReadReg2, ReadReg3, Clear,
    input  ReadData1, ReadData2, ReadData3, ReadValid, ReadErr, Full
  );

  modport slave (
    input  WriteEn, WriteReg, WriteData, ReadEn, ReadReg1, ReadReg2, ReadReg3, Clear,
    output ReadData1, ReadData2, ReadData3, ReadValid, ReadErr, Full
  );

endinterface

// File: rtl/conv_window_regfile_read_port.sv
// One read port of the window register file: write bypass, valid lookup and
// registered read data. portValid is combinational and describes the read
// being sampled at the coming edge.
module regfile_read_port
  import conv_window_regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               readEn,
  input  addr_t              readReg,
  input  logic               writeEn,
  input  addr_t              writeReg,
  input  pixel_t             writeData,
  input  memArray_t          memWords,
  input  logic [DEPTH-1:0]   validBits,
  output pixel_t             readData,
  output logic               portValid
);

  logic   bypassHit;
  pixel_t resolved;

  // Resolve this port: a same-cycle write wins, then stored valid data, else zero.
  always_comb begin
    bypassHit = writeEn && (readReg == writeReg);
    portValid = bypassHit || validBits[readReg];
    resolved  = '0;
    if (bypassHit) begin
      resolved = writeData;
    end else if (validBits[readReg]) begin
      resolved = memWords[readReg];
    end
  end

  // Read data register: loads only on ReadEn, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readData <= '0;
    end else if (readEn) begin
      readData <= resolved;
    end
  end

endmodule

// File: rtl/conv_window_regfile.sv
// 16-entry, 1-write / 3-read register file holding the three-tap pixel window.
// Tracks per-entry valid bits, reports Full, and flags windows that touch
// unwritten entries.
module conv_window_regfile
  import conv_window_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  conv_window_regfile_if.slave  bus
);

  memArray_t        mem;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] validNext;
  logic [2:0]       portValid;

  // Valid vector after this edge: clear first, then the write re-marks its entry.
  always_comb begin
    validNext = valid;
    if (bus.Clear) begin
      validNext = '0;
    end
    if (bus.WriteEn) begin
      validNext[bus.WriteReg] = 1'b1;
    end
  end

  // Storage, valid bits, Full and the window status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem           <= '0;
      valid         <= '0;
      bus.Full      <= 1'b0;
      bus.ReadValid <= 1'b0;
      bus.ReadErr   <= 1'b0;
    end else begin
      if (bus.WriteEn) begin
        mem[bus.WriteReg] <= bus.WriteData;
      end
      valid         <= validNext;
      bus.Full      <= &validNext;
      // Ports see the pre-clear valid bits plus bypass, so a window issued with
      // Clear still returns what was stored before it.
      bus.ReadValid <= bus.ReadEn && (&portValid);
      bus.ReadErr   <= bus.ReadEn && !(&portValid);
    end
  end

  regfile_read_port uPort1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .readEn    (bus.ReadEn),
    .readReg   (bus.ReadReg1),
    .writeEn   (bus.WriteEn),
    .writeReg  (bus.WriteReg),
    .writeData (bus.WriteData),
    .memWords  (mem),
    .validBits (valid),
    .readData  (bus.ReadData1),
    .portValid (portValid[0])
  );

  regfile_read_port uPort2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .readEn    (bus.ReadEn),
    .readReg   (bus.ReadReg2),
    .writeEn   (bus.WriteEn),
    .writeReg  (bus.WriteReg),
    .writeData (bus.WriteData),
    .memWords  (mem),
    .validBits (valid),
    .readData  (bus.ReadData2),
    .portValid (portValid[1])
  );

  regfile_read_port uPort3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .readEn    (bus.ReadEn),
    .readReg   (bus.ReadReg3),
    .writeEn   (bus.WriteEn),
    .writeReg  (bus.WriteReg),
    .writeData (bus.WriteData),
    .memWords  (mem),
    .validBits (valid),
    .readData  (bus.ReadData3),
    .portValid (portValid[2])
  );

endmodule

// File: tb/tb_conv_window_regfile.sv
// Bench for conv_window_regfile: directed windows from the test plan followed by
// random traffic, checked against an array-based reference model.
module tb_conv_window_regfile;
  import conv_window_regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_window_regfile_if bus ();

  conv_window_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model + scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int readsIssued = 0;
  int readsSeen = 0;

  pixel_t refMem [DEPTH];
  bit     refValid [DEPTH];
  pixel_t lastData [3];

  // {ReadValid, ReadErr, ReadData1, ReadData2, ReadData3} per issued read
  logic [3*DATA_W+1:0] readQ [$];
  // {Full, ReadValid, ReadErr, ReadData1, ReadData2, ReadData3} per clock edge
  logic [3*DATA_W+2:0] statQ [$];

  // One clock of stimulus; the model computes what the DUT must show after the edge.
  task automatic step(input int rstN, input int we, input int wr, input int wd,
                      input int re, input int r1, input int r2, input int r3,
                      input int clr);
    int     rr [3];
    pixel_t d [3];
    int     wa;
    pixel_t wv;
    bit     ok, v, e, full;
    @(negedge clk);
    wa = wr % DEPTH;
    wv = pixel_t'(wd & 255);
    rr[0] = r1 % DEPTH;
    rr[1] = r2 % DEPTH;
    rr[2] = r3 % DEPTH;
    rst_n         = (rstN != 0);
    bus.WriteEn   = (we != 0);
    bus.WriteReg  = addr_t'(wa);
    bus.WriteData = wv;
    bus.ReadEn    = (re != 0);
    bus.ReadReg1  = addr_t'(rr[0]);
    bus.ReadReg2  = addr_t'(rr[1]);
    bus.ReadReg3  = addr_t'(rr[2]);
    bus.Clear     = (clr != 0);
    v = 1'b0;
    e = 1'b0;
    if (rstN == 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        refMem[i]   = '0;
        refValid[i] = 1'b0;
      end
      for (int k = 0; k < 3; k++) lastData[k] = '0;
    end else begin
      if (re != 0) begin
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
          if (we != 0 && rr[k] == wa) d[k] = wv;
          else if (refValid[rr[k]]) d[k] = refMem[rr[k]];
          else begin
            d[k] = '0;
            ok = 1'b0;
          end
        end
        v = ok;
        e = !ok;
        readQ.push_back({v, e, d[0], d[1], d[2]});
        readsIssued++;
        for (int k = 0; k < 3; k++) lastData[k] = d[k];
      end
      if (clr != 0) for (int i = 0; i < DEPTH; i++) refValid[i] = 1'b0;
      if (we != 0) begin
        refMem[wa]   = wv;
        refValid[wa] = 1'b1;
      end
    end
    full = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (!refValid[i]) full = 1'b0;
    statQ.push_back({full, v, e, lastData[0], lastData[1], lastData[2]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic doReset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writeWord(input int a, input int d);
    step(1, 1, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic readWin(input int a, input int b, input int c);
    step(1, 0, 0, 0, 1, a, b, c, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [3*DATA_W+2:0] expS, actS;
    logic [3*DATA_W+1:0] expR, actR;
    forever begin
      @(posedge clk);
      #1;
      if (statQ.size() > 0) begin
        expS = statQ.pop_front();
        actS = {bus.Full, bus.ReadValid, bus.ReadErr, bus.ReadData1, bus.ReadData2, bus.ReadData3};
        checks++;
        if (actS !== expS) begin
          errors++;
          $display("FAIL status @%0t: got full/rv/err/data=%h required %h", $time, actS, expS);
        end
      end
      if (bus.ReadValid === 1'b1 || bus.ReadErr === 1'b1) begin
        readsSeen++;
        checks++;
        if (readQ.size() == 0) begin
          errors++;
          $display("FAIL window @%0t: unexpected pulse rv=%b err=%b, required no output",
                   $time, bus.ReadValid, bus.ReadErr);
        end else begin
          expR = readQ.pop_front();
          actR = {bus.ReadValid, bus.ReadErr, bus.ReadData1, bus.ReadData2, bus.ReadData3};
          if (actR !== expR) begin
            errors++;
            $display("FAIL window @%0t: got rv/err/data=%h required %h", $time, actR, expR);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: stimulus did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.WriteEn = 1'b0;
    bus.WriteReg = '0;
    bus.WriteData = '0;
    bus.ReadEn = 1'b0;
    bus.ReadReg1 = '0;
    bus.ReadReg2 = '0;
    bus.ReadReg3 = '0;
    bus.Clear = 1'b0;

    doReset();
    doReset();
    idle();

    // basic window
    writeWord(0, 8'h11);
    writeWord(1, 8'h12);
    writeWord(2, 8'h13);
    readWin(0, 1, 2);
    idle();

    // fresh reset: unwritten window
    doReset();
    readWin(4, 5, 6);
    idle();

    // same-cycle write bypass on the middle tap
    writeWord(6, 8'h66);
    writeWord(8, 8'h88);
    step(1, 1, 7, 8'hA5, 1, 6, 7, 8, 0);
    idle();

    // fill, then clear together with a write
    for (int i = 0; i < DEPTH; i++) writeWord(i, i * 7 + 3);
    idle();
    step(1, 1, 3, 8'h3C, 0, 0, 0, 0, 1);
    readWin(3, 3, 3);
    readWin(2, 3, 4);

    // clear with a read: pre-clear valid bits plus bypass apply
    for (int i = 0; i < DEPTH; i++) writeWord(i, 8'hC0 + i);
    step(1, 1, 1, 8'h5A, 1, 0, 1, 2, 1);
    readWin(0, 1, 2);

    // continuous windows with wrap
    for (int i = 0; i < DEPTH; i++) writeWord(i, 8'h40 + i * 3);
    for (int a = 0; a < 14; a++) readWin(a, a + 1, a + 2);
    readWin(14, 15, 0);
    idle();

    // reset right after a read
    readWin(1, 2, 3);
    doReset();
    idle();
    readWin(1, 2, 3);
    idle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0) ? 1 : 0,
           $urandom_range(0, 1),
           $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 255),
           ($urandom_range(0, 9) < 6) ? 1 : 0,
           $urandom_range(0, DEPTH - 1),
           $urandom_range(0, DEPTH - 1),
           $urandom_range(0, DEPTH - 1),
           ($urandom_range(0, 19) == 0) ? 1 : 0);
    end
    idle();
    idle();
    @(posedge clk);
    #2;

    checks++;
    if (readQ.size() != 0 || statQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d windows / %0d status entries outstanding, required 0 / 0",
               readQ.size(), statQ.size());
    end
    checks++;
    if (readsSeen != readsIssued) begin
      errors++;
      $display("FAIL window_count: got %0d windows, required %0d", readsSeen, readsIssued);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_regfile.md
# conv_window_regfile

Storage side of the single-layer CNN datapath: a 16-entry register file with one write port and three read ports, addressed by the address counter's WriteReg and ReadReg1..3. It captures incoming pixels, tracks which entries hold valid data, and returns the three-tap window as registered read data with a valid strobe to the MAC stage. Same-cycle write/read collisions are resolved by bypass, so the window never returns stale data.

## Interface
- DATA_W, 8, pixel width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- WriteEn  in  1  write strobe
- WriteReg  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- ReadEn  in  1  read strobe for all three ports
- ReadReg1, ReadReg2, ReadReg3  in  ADDR_W  read addresses
- Clear  in  1  invalidate all entries
- ReadData1, ReadData2, ReadData3  out  DATA_W  registered read data
- ReadValid  out  1  one-cycle pulse: window data valid
- ReadErr  out  1  one-cycle pulse: window touched an unwritten entry
- Full  out  1  all 16 entries valid

## Operation
- Synchronous reset (rst_n low at a rising edge): all 16 storage words = 0, all valid bits = 0, ReadData1..3 = 0, ReadValid = 0, ReadErr = 0, Full = 0. Reset overrides every other input in that cycle.
- Write: WriteEn high at an edge sets mem[WriteReg] = WriteData and valid[WriteReg] = 1.
- Clear: Clear high at an edge sets all valid bits to 0. Storage contents are not modified.
- Clear and WriteEn in the same cycle: the clear applies first, then the write. After the edge only valid[WriteReg] = 1.
- Read: ReadEn high at an edge registers the data for all three ports. For each port k:
  - If WriteEn is high and ReadRegk == WriteReg: ReadDatak = WriteData (bypass); the entry counts as valid.
  - Else if valid[ReadRegk] = 1: ReadDatak = mem[ReadRegk].
  - Else: ReadDatak = 0, and the port is flagged invalid.
- ReadValid = 1 only if all three ports resolved valid. ReadErr = 1 if any port was flagged invalid. The two are mutually exclusive.
- Clear in the same cycle as ReadEn: valid bits are evaluated before the clear, except that a bypassed write still counts as valid.
- ReadEn low: ReadData1..3 hold their previous values; ReadValid = 0; ReadErr = 0.
- Duplicate read addresses (e.g. ReadReg1 == ReadReg2) are legal; each port returns the same data.
- Addresses wrap naturally at ADDR_W bits; there is no out-of-range case.
- Full = AND of the valid bits, registered; it reflects the state after the edge.

## Timing
- Write-to-read latency: 0 cycles via bypass. A read issued in the same cycle as the write returns the new data after that edge.
- Read latency: 1 cycle. ReadEn sampled at edge N drives ReadData/ReadValid/ReadErr during cycle N..N+1.
- Back-to-back ReadEn on every cycle gives one window per cycle; there are no stalls and no backpressure.
- Full updates at the same edge as the write or clear that changes it.
- Reset mid-stream: the next cycle shows every output at its reset value. A ReadValid that was pending is dropped.

## Structure
- The shared CNN package holds DATA_W, ADDR_W, and the derived DEPTH constant, shared with the address counter.
- Sub-module regfile_read_port, instantiated three times. It performs the bypass compare, the valid lookup, and the output register for one port, and produces that port's valid flag.
- The top level holds the storage array, the valid vector, the Full register, and the ReadValid/ReadErr reduction.

## Test plan
- Reset, then write 0x11..0x13 to addresses 0,1,2; ReadEn with addresses 0/1/2 -> next cycle ReadData = 0x11/0x12/0x13, ReadValid = 1, ReadErr = 0.
- Fresh reset; ReadEn with addresses 4/5/6 -> ReadData = 0/0/0, ReadValid = 0, ReadErr = 1.
- Write 0xA5 to address 7 in the same cycle as ReadEn on 6/7/8, where 6 and 8 were written earlier -> ReadData2 = 0xA5, ReadValid = 1.
- Write all 16 entries -> Full = 1 after the 16th edge. Clear together with a write of 0x3C to address 3 -> Full = 0; a read of 3/3/3 returns 0x3C ×3 with ReadValid = 1; a read of 2/3/4 gives ReadErr = 1.
- Continuous ReadEn while the addresses step 0→13, with every entry written -> one ReadValid per cycle, each with the correct data. Wrap at address 15→0 is verified with addresses 14/15/0.
- Assert rst_n low in the cycle after a ReadEn -> ReadValid = 0, ReadData = 0, Full = 0; a subsequent read returns ReadErr = 1.
